// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the 7-segment scan driver.
//   SEG_BLANK_CODE : nibble the downstream decoder renders with all segments off
//   MAX_DIGITS     : widest display the helper function handles
//   scan_state_t   : scan FSM states
//   lzb_mask()     : leading-zero blanking mask for a packed BCD word
// ---------------------------------------------------------------------------
package seg_pkg;

  localparam logic [3:0] SEG_BLANK_CODE = 4'hF;
  localparam int         MAX_DIGITS     = 8;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DRIVE
  } scan_state_t;

  // Returns a bit per digit, set where that digit belongs to the unbroken run
  // of zero digits starting at the most significant used digit. Digit 0 is
  // never part of the mask so a value of zero still shows a single "0".
  // Only the lowest 'digits' nibbles of 'bcd' are considered.
  function automatic logic [MAX_DIGITS-1:0] lzb_mask(
    input logic [4*MAX_DIGITS-1:0] bcd,
    input int                      digits
  );
    logic [MAX_DIGITS-1:0] mask;
    logic                  still_zero;
    mask       = '0;
    still_zero = 1'b1;
    for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
      if (i < digits) begin
        if (still_zero && (bcd[4*i +: 4] == 4'h0)) begin
          mask[i] = 1'b1;
        end else begin
          still_zero = 1'b0;
        end
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// ---------------------------------------------------------------------------
// scan_tick_gen
// Slot prescaler for the scan driver. Counts 0..SCAN_DIV-1 and wraps, so one
// full count is exactly one digit slot.
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   clr       : hold the count at zero (scan idle or being disabled)
//   blank_end : high while the count sits on the last dead-time cycle
//   slot_end  : high while the count sits on the last cycle of the slot
// ---------------------------------------------------------------------------
module scan_tick_gen #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic blank_end,
  output logic slot_end
);

  localparam int CNT_W = $clog2(SCAN_DIV);

  logic [CNT_W-1:0] cnt;

  // Free-running slot counter; clr has priority so the first cycle after
  // leaving idle always starts the slot at count zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(SCAN_DIV - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign blank_end = (cnt == CNT_W'(BLANK_CYC - 1));
  assign slot_end  = (cnt == CNT_W'(SCAN_DIV - 1));

endmodule

// File: rtl/seg_scan.sv
// ---------------------------------------------------------------------------
// seg_scan
// Time-multiplexed scan driver for a DIGITS-wide common-anode 7-segment
// display. Each digit gets a slot of SCAN_DIV cycles: BLANK_CYC dark cycles
// to suppress ghosting, then the remainder driving that digit. New data is
// only swapped in at a frame boundary so a frame never mixes two values.
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   en         : scan enable, 0 keeps the display dark
//   lzb_en     : leading-zero blanking enable
//   load       : one-cycle pulse capturing data_in
//   data_in    : packed BCD, nibble i is digit i (digit 0 least significant)
//   digit_num  : nibble for the BCD-to-segment decoder, 4'hF means blank
//   dig_sel    : active-low digit enables, at most one bit low
//   frame_tick : one-cycle pulse on the first cycle of each frame
// ---------------------------------------------------------------------------
module seg_scan
  import seg_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  lzb_en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data_in,
  output logic [3:0]            digit_num,
  output logic [DIGITS-1:0]     dig_sel,
  output logic                  frame_tick
);

  localparam int IDX_W = $clog2(DIGITS);
  localparam int DW    = 4 * DIGITS;

  scan_state_t             state;
  scan_state_t             state_next;
  logic [IDX_W-1:0]        index;
  logic [IDX_W-1:0]        index_next;
  logic                    boundary_next;

  logic [DW-1:0]           shadow;
  logic [DW-1:0]           active;
  logic [DW-1:0]           active_d;
  logic                    pending;
  logic                    pending_d;

  logic                    cnt_clr;
  logic                    blank_end;
  logic                    slot_end;

  logic [4*MAX_DIGITS-1:0] active_ext;
  logic [MAX_DIGITS-1:0]   blank_mask;
  logic [3:0]              num_d;
  logic [DIGITS-1:0]       sel_d;

  // The prescaler is held at zero while idle and on the cycle the scan is
  // being switched off, so every restart begins a clean slot.
  assign cnt_clr = (state == IDLE) || !en;

  scan_tick_gen #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_tick (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (cnt_clr),
    .blank_end (blank_end),
    .slot_end  (slot_end)
  );

  // Double-buffered display data. The registered frame_tick marks the
  // boundary cycle itself; pending data (or a load landing on that very
  // cycle, which wins) is promoted to the active word at its end.
  always_comb begin
    active_d  = active;
    pending_d = pending;
    if (frame_tick) begin
      pending_d = 1'b0;
      if (load) begin
        active_d = data_in;
      end else if (pending) begin
        active_d = shadow;
      end
    end else if (load) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
    end else begin
      if (load) begin
        shadow <= data_in;
      end
      active  <= active_d;
      pending <= pending_d;
    end
  end

  // Scan sequencing. boundary_next flags that the next cycle is the first
  // blank cycle of digit 0, either by wrapping or by starting from idle.
  always_comb begin
    state_next    = state;
    index_next    = index;
    boundary_next = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          state_next    = BLANK;
          index_next    = '0;
          boundary_next = 1'b1;
        end
      end
      BLANK: begin
        if (!en) begin
          state_next = IDLE;
          index_next = '0;
        end else if (blank_end) begin
          state_next = DRIVE;
        end
      end
      DRIVE: begin
        if (!en) begin
          state_next = IDLE;
          index_next = '0;
        end else if (slot_end) begin
          state_next = BLANK;
          if (index == IDX_W'(DIGITS - 1)) begin
            index_next    = '0;
            boundary_next = 1'b1;
          end else begin
            index_next = index + IDX_W'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
        index_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      index <= '0;
    end else begin
      state <= state_next;
      index <= index_next;
    end
  end

  // Output decode is done from the next state and the next active word so the
  // registered outputs line up with the state they describe, including the
  // case where the data swap and the first drive cycle share an edge.
  always_comb begin
    active_ext             = '0;
    active_ext[DW-1:0]     = active_d;
    blank_mask             = lzb_mask(active_ext, DIGITS);
    num_d                  = SEG_BLANK_CODE;
    sel_d                  = '1;
    if (state_next == DRIVE) begin
      sel_d[index_next] = 1'b0;
      if (lzb_en && blank_mask[index_next]) begin
        num_d = SEG_BLANK_CODE;
      end else begin
        num_d = active_d[{index_next, 2'b00} +: 4];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_sel    <= '1;
      digit_num  <= SEG_BLANK_CODE;
      frame_tick <= 1'b0;
    end else begin
      dig_sel    <= sel_d;
      digit_num  <= num_d;
      frame_tick <= boundary_next;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// ---------------------------------------------------------------------------
// tb_seg_scan
// Self-checking bench for seg_scan with a small display (4 digits, 8-cycle
// slots, 2 dead cycles). The reference model tracks time since scan start and
// derives digit, slot phase and frame from plain arithmetic.
// ---------------------------------------------------------------------------
module tb_seg_scan;

  localparam int D     = 4;
  localparam int SD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = D * SD;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        lzb_en;
  logic        load;
  logic [15:0] data_in;
  logic [3:0]  digit_num;
  logic [3:0]  dig_sel;
  logic        frame_tick;

  int errors;
  int checks;

  // Reference model state
  bit          m_run;
  int          m_t;
  logic [15:0] m_active;
  logic [15:0] m_shadow;
  bit          m_pending;
  int          m_idx;
  bit          m_drive;
  logic [3:0]  exp_sel;
  logic [3:0]  exp_num;
  logic        exp_tick;

  seg_scan #(
    .DIGITS    (D),
    .SCAN_DIV  (SD),
    .BLANK_CYC (BC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .lzb_en     (lzb_en),
    .load       (load),
    .data_in    (data_in),
    .digit_num  (digit_num),
    .dig_sel    (dig_sel),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // What digit idx of 'word' looks like: with blanking on, anything above the
  // most significant nonzero digit is dark (digit 0 counts as the floor).
  function automatic logic [3:0] model_digit(logic [15:0] word, int idx, bit lzb);
    int top;
    top = 0;
    for (int i = 0; i < D; i++) begin
      if (word[i*4 +: 4] != 4'h0) top = i;
    end
    if (lzb && idx > top) return 4'hF;
    return word[idx*4 +: 4];
  endfunction

  task automatic model_reset();
    m_run     = 0;
    m_t       = 0;
    m_active  = '0;
    m_shadow  = '0;
    m_pending = 0;
    m_idx     = 0;
    m_drive   = 0;
    exp_sel   = 4'hF;
    exp_num   = 4'hF;
    exp_tick  = 1'b0;
  endtask

  // Advance one clock: update the model from the inputs seen at the edge,
  // then settle 1 time unit so outputs can be sampled away from the edge.
  task automatic step();
    bit was_boundary;
    int p;
    @(posedge clk);
    was_boundary = m_run && (m_t % FRAME == 0);
    if (was_boundary) begin
      if (load) m_active = data_in;
      else if (m_pending) m_active = m_shadow;
      m_pending = 0;
    end else if (load) begin
      m_pending = 1;
    end
    if (load) m_shadow = data_in;
    if (!en) m_run = 0;
    else if (!m_run) begin
      m_run = 1;
      m_t   = 0;
    end else m_t++;
    if (m_run) begin
      p        = m_t % SD;
      m_idx    = (m_t / SD) % D;
      m_drive  = (p >= BC);
      exp_tick = (m_t % FRAME == 0);
      exp_sel  = m_drive ? ~(4'b0001 << m_idx) : 4'hF;
      exp_num  = m_drive ? model_digit(m_active, m_idx, lzb_en) : 4'hF;
    end else begin
      m_drive  = 0;
      exp_tick = 1'b0;
      exp_sel  = 4'hF;
      exp_num  = 4'hF;
    end
    #1;
  endtask

  task automatic test_reset();
    int guard;
    rst_n = 1'b1; en = 1'b0; lzb_en = 1'b0; load = 1'b0; data_in = '0;
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({dig_sel, digit_num, frame_tick} !== {4'b1111, 4'hF, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_state got sel=%b num=%h tick=%b want 1111/f/0", dig_sel, digit_num, frame_tick);
    end
    #9 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({dig_sel, digit_num, frame_tick} !== {4'b1111, 4'hF, 1'b0}) begin
        errors++;
        $display("[TB] FAIL reset_idle cyc=%0d got sel=%b num=%h tick=%b", i, dig_sel, digit_num, frame_tick);
      end
    end
    en    = 1'b1;
    guard = 0;
    do begin
      step();
      guard++;
    end while (exp_sel !== 4'b1101 && guard < 40);
    checks++;
    if (dig_sel !== 4'b1101 || guard >= 40) begin
      errors++;
      $display("[TB] FAIL reset_pre_drive got sel=%b want 1101 (waited %0d)", dig_sel, guard);
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({dig_sel, digit_num, frame_tick} !== {4'b1111, 4'hF, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_async got sel=%b num=%h tick=%b want 1111/f/0", dig_sel, digit_num, frame_tick);
    end
    en = 1'b0;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({dig_sel, digit_num, frame_tick} !== {4'b1111, 4'hF, 1'b0}) begin
        errors++;
        $display("[TB] FAIL reset_release cyc=%0d got sel=%b num=%h tick=%b", i, dig_sel, digit_num, frame_tick);
      end
    end
  endtask

  task automatic test_basic_scan();
    logic [7:0] spot;
    bit         has_spot;
    lzb_en = 1'b0;
    load = 1'b1; data_in = 16'h1234;
    step();
    load = 1'b0; en = 1'b1;
    for (int c = 0; c < 2 * FRAME + 4; c++) begin
      step();
      checks++;
      if ({dig_sel, digit_num, frame_tick} !== {exp_sel, exp_num, exp_tick}) begin
        errors++;
        $display("[TB] FAIL basic_scan t=%0d got sel=%b num=%h tick=%b want sel=%b num=%h tick=%b",
                 m_t, dig_sel, digit_num, frame_tick, exp_sel, exp_num, exp_tick);
      end
      has_spot = 1'b1;
      case (m_t)
        0:  spot = {4'b1111, 4'hF};
        1:  spot = {4'b1111, 4'hF};
        2:  spot = {4'b1110, 4'h4};
        7:  spot = {4'b1110, 4'h4};
        8:  spot = {4'b1111, 4'hF};
        10: spot = {4'b1101, 4'h3};
        18: spot = {4'b1011, 4'h2};
        26: spot = {4'b0111, 4'h1};
        default: has_spot = 1'b0;
      endcase
      if (has_spot) begin
        checks++;
        if ({dig_sel, digit_num} !== spot) begin
          errors++;
          $display("[TB] FAIL basic_spot t=%0d got sel=%b num=%h want %b/%h", m_t, dig_sel, digit_num, spot[7:4], spot[3:0]);
        end
      end
      if (m_t == 32 || m_t == 64) begin
        checks++;
        if (frame_tick !== 1'b1) begin
          errors++;
          $display("[TB] FAIL basic_frame_tick t=%0d got %b want 1", m_t, frame_tick);
        end
      end
    end
  endtask

  task automatic test_lzb();
    logic [3:0]  seen [D];
    logic [15:0] want;
    lzb_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      data_in = (k == 0) ? 16'h0070 : 16'h0000;
      want    = (k == 0) ? 16'hFF70 : 16'hFFF0;
      load = 1'b1;
      step();
      load = 1'b0;
      for (int c = 0; c < 2 * FRAME; c++) begin
        step();
        checks++;
        if ({dig_sel, digit_num, frame_tick} !== {exp_sel, exp_num, exp_tick}) begin
          errors++;
          $display("[TB] FAIL lzb t=%0d got sel=%b num=%h tick=%b want sel=%b num=%h tick=%b",
                   m_t, dig_sel, digit_num, frame_tick, exp_sel, exp_num, exp_tick);
        end
        if (m_drive) seen[m_idx] = digit_num;
      end
      for (int i = 0; i < D; i++) begin
        checks++;
        if (seen[i] !== want[i*4 +: 4]) begin
          errors++;
          $display("[TB] FAIL lzb_digit case=%0d idx=%0d got %h want %h", k, i, seen[i], want[i*4 +: 4]);
        end
      end
    end
    lzb_en = 1'b0;
  endtask

  task automatic test_tear_free();
    logic [3:0] cur [D];
    logic [3:0] nxt [D];
    bit         past_tick;
    int         guard;
    load = 1'b1; data_in = 16'h1234;
    step();
    load = 1'b0;
    guard = 0;
    do begin
      step();
      guard++;
      checks++;
      if ({dig_sel, digit_num, frame_tick} !== {exp_sel, exp_num, exp_tick}) begin
        errors++;
        $display("[TB] FAIL tear_setup t=%0d got sel=%b num=%h tick=%b want sel=%b num=%h tick=%b",
                 m_t, dig_sel, digit_num, frame_tick, exp_sel, exp_num, exp_tick);
      end
    end while (!(guard > FRAME + 2 && m_drive && m_idx == 1) && guard < 200);
    checks++;
    if (guard >= 200) begin
      errors++;
      $display("[TB] FAIL tear_wait_idx1 got timeout want index 1 drive");
    end
    load = 1'b1; data_in = 16'h5678;
    past_tick = 0;
    for (int c = 0; c < 2 * FRAME; c++) begin
      step();
      load = 1'b0;
      checks++;
      if ({dig_sel, digit_num, frame_tick} !== {exp_sel, exp_num, exp_tick}) begin
        errors++;
        $display("[TB] FAIL tear_free t=%0d got sel=%b num=%h tick=%b want sel=%b num=%h tick=%b",
                 m_t, dig_sel, digit_num, frame_tick, exp_sel, exp_num, exp_tick);
      end
      if (exp_tick) past_tick = 1;
      if (m_drive) begin
        if (past_tick) nxt[m_idx] = digit_num;
        else cur[m_idx] = digit_num;
      end
    end
    checks++;
    if ({cur[3], cur[2]} !== 8'h12) begin
      errors++;
      $display("[TB] FAIL tear_old_frame got idx3=%h idx2=%h want 1/2", cur[3], cur[2]);
    end
    checks++;
    if ({nxt[3], nxt[2], nxt[1], nxt[0]} !== 16'h5678) begin
      errors++;
      $display("[TB] FAIL tear_new_frame got %h%h%h%h want 5678", nxt[3], nxt[2], nxt[1], nxt[0]);
    end
    // Load landing exactly on the frame boundary cycle
    guard = 0;
    do begin
      step();
      guard++;
    end while (!exp_tick && guard < 2 * FRAME);
    load = 1'b1; data_in = 16'h4321;
    step();
    load = 1'b0;
    for (int c = 0; c < SD; c++) begin
      step();
      checks++;
      if ({dig_sel, digit_num, frame_tick} !== {exp_sel, exp_num, exp_tick}) begin
        errors++;
        $display("[TB] FAIL tear_coincident t=%0d got sel=%b num=%h tick=%b want sel=%b num=%h tick=%b",
                 m_t, dig_sel, digit_num, frame_tick, exp_sel, exp_num, exp_tick);
      end
      if (m_drive && m_idx == 0) cur[0] = digit_num;
    end
    checks++;
    if (cur[0] !== 4'h1 || guard >= 2 * FRAME) begin
      errors++;
      $display("[TB] FAIL tear_coincident_idx0 got %h want 1 (waited %0d)", cur[0], guard);
    end
  endtask

  task automatic test_double_load();
    logic [3:0] seen [D];
    bit         saw_a;
    int         guard;
    guard = 0;
    do begin
      step();
      guard++;
    end while (!exp_tick && guard < 2 * FRAME);
    for (int i = 0; i < 3; i++) step();
    load = 1'b1; data_in = 16'hAAAA;
    step();
    load = 1'b0;
    step();
    load = 1'b1; data_in = 16'h9999;
    step();
    load = 1'b0;
    saw_a = 0;
    for (int c = 0; c < 2 * FRAME; c++) begin
      step();
      checks++;
      if ({dig_sel, digit_num, frame_tick} !== {exp_sel, exp_num, exp_tick}) begin
        errors++;
        $display("[TB] FAIL double_load t=%0d got sel=%b num=%h tick=%b want sel=%b num=%h tick=%b",
                 m_t, dig_sel, digit_num, frame_tick, exp_sel, exp_num, exp_tick);
      end
      if (m_drive) begin
        seen[m_idx] = digit_num;
        if (digit_num === 4'hA) saw_a = 1;
      end
    end
    checks++;
    if ({seen[3], seen[2], seen[1], seen[0]} !== 16'h9999 || saw_a || guard >= 2 * FRAME) begin
      errors++;
      $display("[TB] FAIL double_load_result got %h%h%h%h saw_a=%0d want 9999 saw_a=0",
               seen[3], seen[2], seen[1], seen[0], saw_a);
    end
  endtask

  task automatic test_enable_drop();
    int guard;
    guard = 0;
    do begin
      step();
      guard++;
    end while (!(m_drive && m_idx == 2) && guard < 2 * FRAME);
    checks++;
    if (dig_sel !== 4'b1011 || guard >= 2 * FRAME) begin
      errors++;
      $display("[TB] FAIL en_drop_pre got sel=%b want 1011", dig_sel);
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({dig_sel, digit_num, frame_tick} !== {4'b1111, 4'hF, 1'b0}) begin
        errors++;
        $display("[TB] FAIL en_drop_dark cyc=%0d got sel=%b num=%h tick=%b want 1111/f/0", i, dig_sel, digit_num, frame_tick);
      end
    end
    en = 1'b1;
    step();
    checks++;
    if ({dig_sel, digit_num, frame_tick} !== {4'b1111, 4'hF, 1'b1}) begin
      errors++;
      $display("[TB] FAIL en_restart got sel=%b num=%h tick=%b want 1111/f/1", dig_sel, digit_num, frame_tick);
    end
    step();
    step();
    checks++;
    if ({dig_sel, digit_num, frame_tick} !== {4'b1110, 4'h9, 1'b0}) begin
      errors++;
      $display("[TB] FAIL en_restart_drive got sel=%b num=%h tick=%b want 1110/9/0", dig_sel, digit_num, frame_tick);
    end
  endtask

  task automatic test_random();
    logic [15:0] w;
    int          r;
    for (int c = 0; c < 3000; c++) begin
      load = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < D; i++) begin
        r = $urandom_range(0, 15);
        w[i*4 +: 4] = (r < 12) ? 4'(r) : 4'h0;
      end
      data_in = w;
      if ($urandom_range(0, 63) == 0) lzb_en = ~lzb_en;
      if (en) begin
        if ($urandom_range(0, 299) == 0) en = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        en = 1'b1;
      end
      step();
      checks++;
      if ({dig_sel, digit_num, frame_tick} !== {exp_sel, exp_num, exp_tick}) begin
        errors++;
        $display("[TB] FAIL random c=%0d t=%0d got sel=%b num=%h tick=%b want sel=%b num=%h tick=%b",
                 c, m_t, dig_sel, digit_num, frame_tick, exp_sel, exp_num, exp_tick);
      end
    end
    load = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic_scan();
    test_lzb();
    test_tear_free();
    test_double_load();
    test_enable_drop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
